// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the ARM-subset control logic: FSM state type,
// instruction field codes, ALU control values, mux selects and flag indices.
package cpu_ctrl_pkg;

  localparam int STATE_W_DEF = 4;
  localparam int FLAG_W_DEF  = 4;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;

  localparam logic [1:0] SRC_A_RN     = 2'b00;
  localparam logic [1:0] SRC_A_PC     = 2'b01;
  localparam logic [1:0] SRC_A_ALUOUT = 2'b10;

  localparam logic [1:0] SRC_B_RM   = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit bus: decoder fields and ALU flags in, datapath enables,
// mux selects, flag register and debug state out.
//   master : the control unit (drives enables/selects)
//   slave  : the datapath side (drives instruction fields and alu_flags)
interface multicycle_control_unit_if #(
  parameter int STATE_W = 4,
  parameter int FLAG_W  = 4
);
  logic [3:0]         cond;
  logic [1:0]         op;
  logic [5:0]         funct;
  logic [3:0]         rd;
  logic [FLAG_W-1:0]  alu_flags;
  logic               pc_write;
  logic               ir_write;
  logic               mem_write;
  logic               reg_write;
  logic               adr_src;
  logic [1:0]         alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         result_src;
  logic [2:0]         alu_control;
  logic [FLAG_W-1:0]  flags;
  logic [STATE_W-1:0] state;

  modport master (
    input  cond, op, funct, rd, alu_flags,
    output pc_write, ir_write, mem_write, reg_write, adr_src,
           alu_src_a, alu_src_b, result_src, alu_control, flags, state
  );

  modport slave (
    output cond, op, funct, rd, alu_flags,
    input  pc_write, ir_write, mem_write, reg_write, adr_src,
           alu_src_a, alu_src_b, result_src, alu_control, flags, state
  );
endinterface

// File: rtl/cond_check.sv
// ARM condition-code evaluation (combinational).
//   cond    : instruction bits 31:28
//   flags   : NZCV
//   cond_ok : 1 when the instruction should execute (1111 never executes)
module cond_check
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ok
);
  logic n, z, c, v, ge;

  always_comb begin
    n  = flags[FLAG_N];
    z  = flags[FLAG_Z];
    c  = flags[FLAG_C];
    v  = flags[FLAG_V];
    ge = (n == v);
    case (cond)
      4'b0000: cond_ok = z;
      4'b0001: cond_ok = ~z;
      4'b0010: cond_ok = c;
      4'b0011: cond_ok = ~c;
      4'b0100: cond_ok = n;
      4'b0101: cond_ok = ~n;
      4'b0110: cond_ok = v;
      4'b0111: cond_ok = ~v;
      4'b1000: cond_ok = c & ~z;
      4'b1001: cond_ok = ~c | z;
      4'b1010: cond_ok = ge;
      4'b1011: cond_ok = ~ge;
      4'b1100: cond_ok = ~z & ge;
      4'b1101: cond_ok = z | ~ge;
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end
endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM for the ARM-subset processor.
//   clk, rst : clock, synchronous active-high reset
//   bus      : decoder fields / alu_flags in; enables, selects, flags, state out
// Outputs are decoded from state. Selects not named for a state default to
// 0 / ADD. Write enables after DECODE are gated by the latched condition.
module multicycle_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int STATE_W = 4,
  parameter int FLAG_W  = 4
) (
  input logic                      clk,
  input logic                      rst,
  multicycle_control_unit_if.master bus
);
  state_t            state_q, state_d;
  logic [FLAG_W-1:0] flags_q;
  logic              cond_ok, cond_ok_q;
  logic              i_bit, s_bit, is_cmp;
  logic [3:0]        cmd;
  logic [2:0]        exec_ctrl;
  logic              exec_wb;
  logic              pcw, irw, mw, rw, wr_ok;

  assign i_bit  = bus.funct[5];
  assign cmd    = bus.funct[4:1];
  assign s_bit  = bus.funct[0];
  assign is_cmp = (cmd == CMD_CMP);

  cond_check u_cond_check (
    .cond    (bus.cond),
    .flags   (flags_q[3:0]),
    .cond_ok (cond_ok)
  );

  always_comb begin
    exec_ctrl = ALU_ADD;
    exec_wb   = 1'b1;
    case (cmd)
      CMD_ADD: exec_ctrl = ALU_ADD;
      CMD_SUB: exec_ctrl = ALU_SUB;
      CMD_AND: exec_ctrl = ALU_AND;
      CMD_ORR: exec_ctrl = ALU_ORR;
      CMD_CMP: begin exec_ctrl = ALU_SUB; exec_wb = 1'b0; end
      default: exec_wb = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      flags_q   <= '0;
      cond_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) cond_ok_q <= cond_ok;
      if ((state_q == S_EXECR || state_q == S_EXECI) && cond_ok_q && (s_bit || is_cmp))
        flags_q <= bus.alu_flags;
    end
  end

  always_comb begin
    state_d         = S_FETCH;
    pcw             = 1'b0;
    irw             = 1'b0;
    mw              = 1'b0;
    rw              = 1'b0;
    bus.adr_src     = 1'b0;
    bus.alu_src_a   = SRC_A_RN;
    bus.alu_src_b   = SRC_B_RM;
    bus.result_src  = RES_ALUOUT;
    bus.alu_control = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        irw            = 1'b1;
        pcw            = 1'b1;
        bus.alu_src_a  = SRC_A_PC;
        bus.alu_src_b  = SRC_B_FOUR;
        bus.result_src = RES_ALU;
        state_d        = S_DECODE;
      end
      S_DECODE: begin
        bus.alu_src_a = SRC_A_PC;
        bus.alu_src_b = SRC_B_FOUR;
        if (cond_ok) begin
          case (bus.op)
            OP_MEM:  state_d = S_MEMADR;
            OP_BR:   state_d = S_BRANCH;
            OP_DP:   state_d = i_bit ? S_EXECI : S_EXECR;
            default: state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        bus.alu_src_b = SRC_B_IMM;
        state_d       = s_bit ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        bus.adr_src = 1'b1;
        state_d     = S_MEMWB;
      end
      S_MEMWB: begin
        bus.result_src = RES_RDATA;
        if (bus.rd == 4'd15) pcw = 1'b1;
        else                 rw  = 1'b1;
      end
      S_MEMWR: begin
        bus.adr_src = 1'b1;
        mw          = 1'b1;
      end
      S_EXECR, S_EXECI: begin
        bus.alu_src_b   = (state_q == S_EXECI) ? SRC_B_IMM : SRC_B_RM;
        bus.alu_control = exec_ctrl;
        state_d         = exec_wb ? S_ALUWB : S_FETCH;
      end
      S_ALUWB: begin
        bus.result_src = RES_ALUOUT;
        if (bus.rd == 4'd15) pcw = 1'b1;
        else                 rw  = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a  = SRC_A_ALUOUT;
        bus.alu_src_b  = SRC_B_IMM;
        bus.result_src = RES_ALU;
        pcw            = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // FETCH writes belong to the next instruction, so only later states use the latch.
  assign wr_ok = (state_q == S_FETCH) || cond_ok_q;

  assign bus.pc_write  = pcw & wr_ok & ~rst;
  assign bus.ir_write  = irw & wr_ok & ~rst;
  assign bus.mem_write = mw  & wr_ok & ~rst;
  assign bus.reg_write = rw  & wr_ok & ~rst;
  assign bus.flags     = flags_q;
  assign bus.state     = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_bad   = 0;
  logic [3:0] flags_model;

  always #5 clk = ~clk;

  multicycle_control_unit_if #(.STATE_W(4), .FLAG_W(4)) bus ();

  multicycle_control_unit #(.STATE_W(4), .FLAG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // One expected cycle; -1 in a select means the instruction class does not fix it.
  typedef struct {
    int st;
    int pcw, irw, mw, rw;
    int adr, sa, sb, rs, ac;
    bit upd;
  } exp_t;

  exp_t exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(int st, int pcw, int irw, int mw, int rw,
                              int adr, int sa, int sb, int rs, int ac, bit upd);
    exp_t e;
    e.st = st; e.pcw = pcw; e.irw = irw; e.mw = mw; e.rw = rw;
    e.adr = adr; e.sa = sa; e.sb = sb; e.rs = rs; e.ac = ac; e.upd = upd;
    return e;
  endfunction

  // Condition codes come in complementary pairs: evaluate the even member, invert for odd.
  function automatic bit passes(logic [3:0] c, logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c == 4'hF) return 1'b0;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = (n == v) && !z;
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  // Instruction-level model: list of cycles the instruction occupies.
  task automatic build_expect(input logic [31:0] ir);
    logic [3:0] c, cmd, rd;
    logic [1:0] op;
    bit ibit, sbit, supported, writes;
    int ac;
    c = ir[31:28]; op = ir[27:26]; ibit = ir[25]; cmd = ir[24:21];
    sbit = ir[20]; rd = ir[15:12];
    exp_q.delete();
    exp_q.push_back(mk(0, 1, 1, 0, 0, 0, 1, 2, 2, 0, 0));
    exp_q.push_back(mk(1, 0, 0, 0, 0, -1, 1, 2, -1, 0, 0));
    if (!passes(c, flags_model) || op == 2'b11) return;
    if (op == 2'b10) begin
      exp_q.push_back(mk(9, 1, 0, 0, 0, -1, 2, 1, 2, 0, 0));
    end else if (op == 2'b01) begin
      exp_q.push_back(mk(2, 0, 0, 0, 0, -1, 0, 1, -1, 0, 0));
      if (sbit) begin
        exp_q.push_back(mk(3, 0, 0, 0, 0, 1, -1, -1, -1, -1, 0));
        exp_q.push_back(mk(4, rd == 15, 0, 0, rd != 15, -1, -1, -1, 1, -1, 0));
      end else begin
        exp_q.push_back(mk(5, 0, 0, 1, 0, 1, -1, -1, -1, -1, 0));
      end
    end else begin
      supported = 1'b1; writes = 1'b1;
      case (cmd)
        4'b0100: ac = 0;
        4'b0010: ac = 1;
        4'b0000: ac = 2;
        4'b1100: ac = 3;
        4'b1010: begin ac = 1; writes = 1'b0; end
        default: begin ac = 0; supported = 1'b0; end
      endcase
      exp_q.push_back(mk(ibit ? 7 : 6, 0, 0, 0, 0, -1, 0, ibit ? 1 : 0, -1, ac,
                         sbit || cmd == 4'b1010));
      if (supported && writes)
        exp_q.push_back(mk(8, rd == 15, 0, 0, rd != 15, -1, -1, -1, 0, -1, 0));
    end
  endtask

  // Entered and left just after a rising edge with the DUT in FETCH.
  task automatic run_instr(input logic [31:0] ir, input bit fix_af,
                           input logic [3:0] af_fixed, input int abort_st);
    exp_t r;
    logic [3:0] af;
    build_expect(ir);
    for (int i = 0; i < exp_q.size(); i++) begin
      r = exp_q[i];
      if (i == 0) begin
        bus.cond  = ir[31:28];
        bus.op    = ir[27:26];
        bus.funct = ir[25:20];
        bus.rd    = ir[15:12];
      end
      af = fix_af ? af_fixed : 4'($urandom);
      bus.alu_flags = af;
      if (r.st == abort_st) begin
        rst = 1'b1;
        #1;
        check_val("abort.mem_write", 32'(bus.mem_write), 0);
        check_val("abort.reg_write", 32'(bus.reg_write), 0);
        check_val("abort.pc_write", 32'(bus.pc_write), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        flags_model = 4'b0000;
        #1;
        check_val("abort.state", 32'(bus.state), 0);
        check_val("abort.flags", 32'(bus.flags), 0);
        check_val("abort.mem_write_after", 32'(bus.mem_write), 0);
        return;
      end
      #1;
      check_val($sformatf("c%0d.state", i), 32'(bus.state), r.st);
      check_val($sformatf("s%0d.pc_write", r.st), 32'(bus.pc_write), r.pcw);
      check_val($sformatf("s%0d.ir_write", r.st), 32'(bus.ir_write), r.irw);
      check_val($sformatf("s%0d.mem_write", r.st), 32'(bus.mem_write), r.mw);
      check_val($sformatf("s%0d.reg_write", r.st), 32'(bus.reg_write), r.rw);
      check_val($sformatf("s%0d.flags", r.st), 32'(bus.flags), 32'(flags_model));
      if (r.adr >= 0) check_val($sformatf("s%0d.adr_src", r.st), 32'(bus.adr_src), r.adr);
      if (r.sa  >= 0) check_val($sformatf("s%0d.alu_src_a", r.st), 32'(bus.alu_src_a), r.sa);
      if (r.sb  >= 0) check_val($sformatf("s%0d.alu_src_b", r.st), 32'(bus.alu_src_b), r.sb);
      if (r.rs  >= 0) check_val($sformatf("s%0d.result_src", r.st), 32'(bus.result_src), r.rs);
      if (r.ac  >= 0) check_val($sformatf("s%0d.alu_control", r.st), 32'(bus.alu_control), r.ac);
      @(posedge clk);
      if (r.upd) flags_model = af;
      #1;
    end
  endtask

  function automatic logic [31:0] rand_ir();
    logic [3:0] c, cmd, rd;
    logic [1:0] op;
    logic [3:0] cmds [5];
    cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000;
    cmds[3] = 4'b1100; cmds[4] = 4'b1010;
    c   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hE;
    op  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
    cmd = ($urandom_range(0, 5) == 0) ? 4'($urandom) : cmds[$urandom_range(0, 4)];
    rd  = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
    return {c, op, 1'($urandom), cmd, 1'($urandom), 4'($urandom), rd, 12'($urandom)};
  endfunction

  initial begin
    rst = 1'b1;
    bus.cond = 4'hE; bus.op = 2'b00; bus.funct = '0; bus.rd = '0; bus.alu_flags = '0;
    flags_model = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_val("rst.pc_write", 32'(bus.pc_write), 0);
      check_val("rst.ir_write", 32'(bus.ir_write), 0);
      check_val("rst.mem_write", 32'(bus.mem_write), 0);
      check_val("rst.reg_write", 32'(bus.reg_write), 0);
    end
    rst = 1'b0;
    #1;
    check_val("rst.state", 32'(bus.state), 0);
    check_val("rst.flags", 32'(bus.flags), 0);

    run_instr(32'hE0475001, 1'b0, 4'h0, -1);   // SUB R5,R7,R1
    run_instr(32'hE5949010, 1'b0, 4'h0, -1);   // LDR R9,[R4,#16]
    run_instr(32'hE1530004, 1'b1, 4'b1000, -1); // CMP -> N=1, V=0
    run_instr(32'hBA000003, 1'b0, 4'h0, -1);   // BLT taken
    run_instr(32'hE1530004, 1'b1, 4'b0000, -1); // CMP -> flags clear
    run_instr(32'hBA000003, 1'b0, 4'h0, -1);   // BLT not taken
    run_instr(32'hE1530004, 1'b1, 4'b0100, -1); // CMP -> Z=1
    run_instr(32'hE5841000, 1'b0, 4'h0, 5);    // STR aborted by reset in MEMWR
    run_instr(32'hE5841000, 1'b0, 4'h0, -1);   // STR completes
    run_instr(32'hF0475001, 1'b0, 4'h0, -1);   // cond NV
    run_instr(32'hE280F004, 1'b0, 4'h0, -1);   // ADD PC,R0,#4

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 49) == 0)
        run_instr(32'hE5841000, 1'b0, 4'h0, 5);
      else
        run_instr(rand_ir(), 1'b0, 4'h0, -1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
